eda_regmax_ctrl: RTL and testbench

EDA_REGMAX_CTRL -- requirements
Module: eda_regmax_ctrl

---
 rtl/eda_regmax_ctrl.sv | 168 ++++++++++++++++
 tb/tb_eda_regmax_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/eda_regmax_ctrl.sv
// Frame-load / engine-handshake controller: streams an MxN pixel frame into the
// engine RAM, pulses start, waits for done with a timeout, and holds the result.
module eda_regmax_ctrl #(
   parameter int M              = 4,
   parameter int N              = 4,
   parameter int PIXEL_WIDTH    = 8,
   parameter int I_WIDTH        = 2,
   parameter int J_WIDTH        = 2,
   parameter int ADDR_WIDTH     = I_WIDTH + J_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   s_valid,
   input  logic [PIXEL_WIDTH-1:0] s_pixel,
   output logic                   s_ready,
   input  logic                   abort,
   output logic [ADDR_WIDTH-1:0]  wr_addr,
   output logic [PIXEL_WIDTH-1:0] pixel_out,
   output logic                   write_en,
   output logic                   start,
   input  logic                   done,
   input  logic [M*N-1:0]         matrix_in,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [M*N-1:0]         res_matrix,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [2:0]             state_dbg
);

   localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [I_WIDTH-1:0] I_LAST  = I_WIDTH'(M - 1);
   localparam logic [J_WIDTH-1:0] J_LAST  = J_WIDTH'(N - 1);
   localparam logic [WCW-1:0]     WC_LAST = WCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {LOAD, SETTLE, START, WAIT, RESULT} state_t;

   state_t                 state, state_n;
   logic [I_WIDTH-1:0]     i, i_n;
   logic [J_WIDTH-1:0]     j, j_n;
   logic                   settle_cnt, settle_cnt_n;
   logic [WCW-1:0]         wcnt, wcnt_n;
   logic                   done_q;
   logic [ADDR_WIDTH-1:0]  wr_addr_n;
   logic [PIXEL_WIDTH-1:0] pixel_out_n;
   logic                   write_en_n, start_n, res_valid_n, timeout_n, busy_n;
   logic [M*N-1:0]         res_matrix_n;
   logic                   accept, done_rise;

   // Both handshakes transfer on a cycle where valid && ready are high at the
   // clock edge; s_ready is the only combinational output (decoded from state).
   assign s_ready   = (state == LOAD);
   assign accept    = s_valid && s_ready;
   assign done_rise = done && !done_q;
   assign state_dbg = state;

   always_comb begin
      state_n      = state;
      i_n          = i;
      j_n          = j;
      settle_cnt_n = settle_cnt;
      wcnt_n       = wcnt;
      wr_addr_n    = wr_addr;
      pixel_out_n  = pixel_out;
      write_en_n   = 1'b0;
      start_n      = 1'b0;
      res_valid_n  = res_valid;
      res_matrix_n = res_matrix;
      timeout_n    = timeout_err;
      if (abort) begin
         state_n     = LOAD;
         i_n         = '0;
         j_n         = '0;
         res_valid_n = 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (accept) begin
                  write_en_n  = 1'b1;
                  wr_addr_n   = ADDR_WIDTH'({i, j});
                  pixel_out_n = s_pixel;
                  if (j == J_LAST) begin
                     j_n = '0;
                     if (i == I_LAST) begin
                        i_n          = '0;
                        state_n      = SETTLE;
                        settle_cnt_n = 1'b0;
                     end else begin
                        i_n = i + I_WIDTH'(1);
                     end
                  end else begin
                     j_n = j + J_WIDTH'(1);
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt) begin
                  state_n = START;
                  start_n = 1'b1;
               end else begin
                  settle_cnt_n = 1'b1;
               end
            end
            START: begin
               state_n = WAIT;
               wcnt_n  = '0;
            end
            WAIT: begin
               // A done edge on the final counted cycle still wins over timeout.
               if (done_rise) begin
                  res_matrix_n = matrix_in;
                  res_valid_n  = 1'b1;
                  state_n      = RESULT;
               end else if (wcnt == WC_LAST) begin
                  timeout_n = 1'b1;
                  state_n   = LOAD;
               end else begin
                  wcnt_n = wcnt + WCW'(1);
               end
            end
            RESULT: begin
               if (res_valid && res_ready) begin
                  res_valid_n = 1'b0;
                  state_n     = LOAD;
               end
            end
            default: state_n = LOAD;
         endcase
      end
      busy_n = (state_n != LOAD) || (i_n != '0) || (j_n != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= LOAD;
         i           <= '0;
         j           <= '0;
         settle_cnt  <= 1'b0;
         wcnt        <= '0;
         done_q      <= 1'b0;
         wr_addr     <= '0;
         pixel_out   <= '0;
         write_en    <= 1'b0;
         start       <= 1'b0;
         res_valid   <= 1'b0;
         res_matrix  <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         i           <= i_n;
         j           <= j_n;
         settle_cnt  <= settle_cnt_n;
         wcnt        <= wcnt_n;
         done_q      <= done;
         wr_addr     <= wr_addr_n;
         pixel_out   <= pixel_out_n;
         write_en    <= write_en_n;
         start       <= start_n;
         res_valid   <= res_valid_n;
         res_matrix  <= res_matrix_n;
         busy        <= busy_n;
         timeout_err <= timeout_n;
      end
   end

endmodule

// File: tb/tb_eda_regmax_ctrl.sv
// Directed bench for eda_regmax_ctrl: frame loading, start timing, done capture,
// timeout, abort and asynchronous reset behaviour with hand-computed expectations.
module tb_eda_regmax_ctrl;

   logic        clk;
   logic        reset_n;
   logic        s_valid;
   logic [7:0]  s_pixel;
   logic        s_ready;
   logic        abort;
   logic [3:0]  wr_addr;
   logic [7:0]  pixel_out;
   logic        write_en;
   logic        start;
   logic        done;
   logic [15:0] matrix_in;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_matrix;
   logic        busy;
   logic        timeout_err;
   logic [2:0]  state_dbg;

   int checks   = 0;
   int failures = 0;
   logic rv_seen;

   eda_regmax_ctrl dut (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_pixel(s_pixel),
      .s_ready(s_ready), .abort(abort), .wr_addr(wr_addr), .pixel_out(pixel_out),
      .write_en(write_en), .start(start), .done(done), .matrix_in(matrix_in),
      .res_valid(res_valid), .res_ready(res_ready), .res_matrix(res_matrix),
      .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the active edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] pix, input logic [3:0] exp_addr, input string tag);
      s_valid = 1'b1;
      s_pixel = pix;
      tick();
      s_valid = 1'b0;
      check({tag, "_we"},   {31'd0, write_en}, 32'd1);
      check({tag, "_addr"}, {28'd0, wr_addr},  {28'd0, exp_addr});
      check({tag, "_pix"},  {24'd0, pixel_out}, {24'd0, pix});
   endtask

   // Called right after the final pixel was accepted: start is high in the
   // third cycle after that edge, then WAIT begins.
   task automatic run_to_wait(input string tag);
      check({tag, "_sready_drop"}, {31'd0, s_ready}, 32'd0);
      check({tag, "_start_e0"},    {31'd0, start},   32'd0);
      tick();
      check({tag, "_we_e1"},    {31'd0, write_en}, 32'd0);
      check({tag, "_start_e1"}, {31'd0, start},    32'd0);
      tick();
      check({tag, "_start_e2"}, {31'd0, start}, 32'd1);
      check({tag, "_busy_e2"},  {31'd0, busy},  32'd1);
      tick();
      check({tag, "_start_e3"}, {31'd0, start},     32'd0);
      check({tag, "_wait_st"},  {29'd0, state_dbg}, 32'd3);
   endtask

   initial begin
      reset_n   = 1'b0;
      s_valid   = 1'b0;
      s_pixel   = 8'h00;
      abort     = 1'b0;
      done      = 1'b0;
      matrix_in = 16'h0000;
      res_ready = 1'b0;
      #1;
      check("rst_sready", {31'd0, s_ready},   32'd1);
      check("rst_we",     {31'd0, write_en},  32'd0);
      check("rst_busy",   {31'd0, busy},      32'd0);
      check("rst_rvalid", {31'd0, res_valid}, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("idle_sready", {31'd0, s_ready}, 32'd1);

      // Back-to-back frame 0x00..0x0F, then no done -> timeout after 64 WAIT cycles.
      for (int k = 0; k < 16; k++) beat(8'(k), 4'(k), "b2b");
      run_to_wait("b2b");
      rv_seen = 1'b0;
      for (int k = 0; k < 63; k++) begin
         tick();
         rv_seen = rv_seen | res_valid;
      end
      check("to_not_yet",  {31'd0, timeout_err}, 32'd0);
      check("to_busy_pre", {31'd0, busy},        32'd1);
      tick();
      rv_seen = rv_seen | res_valid;
      check("to_flag",    {31'd0, timeout_err}, 32'd1);
      check("to_load",    {31'd0, s_ready},     32'd1);
      check("to_busy",    {31'd0, busy},        32'd0);
      check("to_rv_seen", {31'd0, rv_seen},     32'd0);
      done      = 1'b1;
      matrix_in = 16'hFFFF;
      tick();
      tick();
      check("late_done_rv",  {31'd0, res_valid},  32'd0);
      check("late_done_mat", {16'd0, res_matrix}, 32'd0);

      // Every-other-cycle frame, done held high from before WAIT.
      for (int k = 0; k < 16; k++) begin
         beat(8'(8'h20 + k), 4'(k), "alt");
         if (k != 15) begin
            tick();
            check("alt_gap_we", {31'd0, write_en}, 32'd0);
         end
      end
      run_to_wait("alt");
      for (int k = 0; k < 3; k++) begin
         tick();
         check("done_level_ign", {31'd0, res_valid}, 32'd0);
      end
      done = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check("pre_rise_rv", {31'd0, res_valid}, 32'd0);
      done      = 1'b1;
      matrix_in = 16'hA5C3;
      tick();
      check("cap_rv",  {31'd0, res_valid},  32'd1);
      check("cap_mat", {16'd0, res_matrix}, 32'h0000A5C3);
      matrix_in = 16'h0000;
      done      = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("hold_rv",  {31'd0, res_valid},  32'd1);
         check("hold_mat", {16'd0, res_matrix}, 32'h0000A5C3);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("drain_rv",     {31'd0, res_valid},   32'd0);
      check("drain_sready", {31'd0, s_ready},     32'd1);
      check("drain_busy",   {31'd0, busy},        32'd0);
      check("sticky_to",    {31'd0, timeout_err}, 32'd1);

      // Reset in the middle of WAIT.
      for (int k = 0; k < 16; k++) beat(8'(8'h40 + k), 4'(k), "fc");
      run_to_wait("fc");
      for (int k = 0; k < 5; k++) tick();
      reset_n = 1'b0;
      #1;
      check("mid_rst_sready", {31'd0, s_ready},     32'd1);
      check("mid_rst_we",     {31'd0, write_en},    32'd0);
      check("mid_rst_start",  {31'd0, start},       32'd0);
      check("mid_rst_addr",   {28'd0, wr_addr},     32'd0);
      check("mid_rst_pix",    {24'd0, pixel_out},   32'd0);
      check("mid_rst_rv",     {31'd0, res_valid},   32'd0);
      check("mid_rst_mat",    {16'd0, res_matrix},  32'd0);
      check("mid_rst_busy",   {31'd0, busy},        32'd0);
      check("mid_rst_to",     {31'd0, timeout_err}, 32'd0);
      tick();
      reset_n = 1'b1;
      beat(8'h77, 4'd0, "post_rst");

      // Abort after 7 beats; the beat presented with abort is dropped.
      for (int k = 1; k < 7; k++) beat(8'(8'h77 + k), 4'(k), "pre_abort");
      abort   = 1'b1;
      s_valid = 1'b1;
      s_pixel = 8'hEE;
      tick();
      abort   = 1'b0;
      s_valid = 1'b0;
      check("abort_we",     {31'd0, write_en}, 32'd0);
      check("abort_busy",   {31'd0, busy},     32'd0);
      check("abort_sready", {31'd0, s_ready},  32'd1);
      beat(8'h99, 4'd0, "post_abort");
      for (int k = 1; k < 16; k++) beat(8'(8'h80 + k), 4'(k), "fd");
      run_to_wait("fd");
      done      = 1'b1;
      matrix_in = 16'h1234;
      tick();
      check("fd_rv",  {31'd0, res_valid},  32'd1);
      check("fd_mat", {16'd0, res_matrix}, 32'h00001234);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      done  = 1'b0;
      check("abort_res_rv",     {31'd0, res_valid}, 32'd0);
      check("abort_res_sready", {31'd0, s_ready},   32'd1);
      check("abort_res_busy",   {31'd0, busy},      32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
